// File: rtl/pe_bs_requant_drain_if.sv
// Output stream from the requant drain to the activation buffer.
interface pe_bs_requant_drain_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_idx;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data, out_idx, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_idx, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/pe_bs_requant_drain.sv
// Drain stage for the three-lane barrel-shift PE: captures the accumulator
// triplet, requantizes each lane (round-half-up, shift, saturate) and
// serializes the three words over a valid/ready stream.
//
// state | meaning
// IDLE  | no triplet held, waiting for cap
// L0    | presenting lane 0 (y1)
// L1    | presenting lane 1 (y2)
// L2    | presenting lane 2 (y3), last word of the triplet
module pe_bs_requant_drain #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SH_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] y1,
  input  logic [IN_W-1:0] y2,
  input  logic [IN_W-1:0] y3,
  input  logic            cap,
  input  logic [SH_W-1:0] qshift,
  output logic            busy,
  output logic            overrun,
  input  logic            clr_ovr,
  pe_bs_requant_drain_if.master bus
);

  typedef enum logic [1:0] {IDLE, L0, L1, L2} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] sh_y1, sh_y2, sh_y3;
  logic [SH_W-1:0] sh_q;
  logic            fire;
  logic            capture;
  logic            drop;

  // One extra bit keeps v + rnd from wrapping at full-scale inputs.
  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] v,
                                               input logic [SH_W-1:0] q);
    logic [IN_W:0] rnd;
    logic [IN_W:0] sum;
    logic [IN_W:0] r;
    rnd = (q == '0) ? '0 : ((IN_W+1)'(1) << (q - SH_W'(1)));
    sum = {1'b0, v} + rnd;
    r   = sum >> q;
    if (|r[IN_W:OUT_W]) return {OUT_W{1'b1}};
    return r[OUT_W-1:0];
  endfunction

  assign fire = bus.out_valid && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, capture/drop decisions and stream outputs from held state.
  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    drop          = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = 2'd0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    case (state)
      IDLE: begin
        if (cap) begin
          capture   = 1'b1;
          state_nxt = L0;
        end
      end
      L0: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = 2'd0;
        bus.out_data  = requant(sh_y1, sh_q);
        drop          = cap;
        if (fire) state_nxt = L1;
      end
      L1: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = 2'd1;
        bus.out_data  = requant(sh_y2, sh_q);
        drop          = cap;
        if (fire) state_nxt = L2;
      end
      L2: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = 2'd2;
        bus.out_last  = 1'b1;
        bus.out_data  = requant(sh_y3, sh_q);
        if (fire) begin
          // Back-to-back triplet: recapture on the final handshake, no bubble.
          capture   = cap;
          state_nxt = cap ? L0 : IDLE;
        end else begin
          drop = cap;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow registers hold the triplet so PE inputs can move on freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_y1 <= '0;
      sh_y2 <= '0;
      sh_y3 <= '0;
      sh_q  <= '0;
    end else if (capture) begin
      sh_y1 <= y1;
      sh_y2 <= y2;
      sh_y3 <= y3;
      sh_q  <= qshift;
    end
  end

  // Sticky overrun flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)          overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pe_bs_requant_drain.sv
// Self-checking bench for pe_bs_requant_drain: directed vector table,
// hand-written stall/overrun/reset sequences, and randomized triplets
// checked against an arithmetic reference model.
module tb_pe_bs_requant_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] y1, y2, y3;
  logic        cap;
  logic [3:0]  qshift;
  logic        busy;
  logic        overrun;
  logic        clr_ovr;

  int n_pass = 0;
  int n_tot  = 0;

  pe_bs_requant_drain_if #(.OUT_W(8)) bus ();

  pe_bs_requant_drain #(.IN_W(16), .OUT_W(8), .SH_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .cap     (cap),
    .qshift  (qshift),
    .busy    (busy),
    .overrun (overrun),
    .clr_ovr (clr_ovr),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y1, y2, y3, q;
    int e0, e1, e2;
  } vec_t;

  // Reference: round half up to nearest integer of v / 2^q, clamp to 255.
  function automatic int model(input int v, input int q);
    int div, half, r;
    div  = 1 << q;
    half = div / 2;
    r    = (v + half) / div;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic load(input int a, input int b, input int c, input int q);
    y1 = 16'(a); y2 = 16'(b); y3 = 16'(c); qshift = 4'(q);
    cap = 1'b1;
  endtask

  task automatic scramble();
    y1 = 16'($urandom); y2 = 16'($urandom); y3 = 16'($urandom);
    qshift = 4'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string s;
    s = $sformatf("vec%0d", n);
    bus.out_ready = 1'b1;
    load(v.y1, v.y2, v.y3, v.q);
    tick();
    cap = 1'b0;
    scramble();
    chk({s, " valid0"}, int'(bus.out_valid), 1);
    chk({s, " idx0"},   int'(bus.out_idx), 0);
    chk({s, " data0"},  int'(bus.out_data), v.e0);
    chk({s, " last0"},  int'(bus.out_last), 0);
    chk({s, " busy0"},  int'(busy), 1);
    tick();
    chk({s, " idx1"},   int'(bus.out_idx), 1);
    chk({s, " data1"},  int'(bus.out_data), v.e1);
    chk({s, " last1"},  int'(bus.out_last), 0);
    tick();
    chk({s, " idx2"},   int'(bus.out_idx), 2);
    chk({s, " data2"},  int'(bus.out_data), v.e2);
    chk({s, " last2"},  int'(bus.out_last), 1);
    tick();
    chk({s, " valid_end"}, int'(bus.out_valid), 0);
    chk({s, " busy_end"},  int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   exp_d[3];
    int   held;
    int   a, b, c, q, k, cyc;

    vecs[0] = '{100,   300,   65535, 0,  100, 255, 255};
    vecs[1] = '{5,     6,     1022,  2,  1,   2,   255};
    vecs[2] = '{16384, 16383, 65535, 15, 1,   0,   2};
    vecs[3] = '{0,     255,   256,   0,  0,   255, 255};
    vecs[4] = '{510,   511,   509,   1,  255, 255, 255};
    vecs[5] = '{65535, 0,     32767, 8,  255, 0,   128};

    rst = 1'b1; cap = 1'b0; clr_ovr = 1'b0; bus.out_ready = 1'b0;
    y1 = '0; y2 = '0; y3 = '0; qshift = '0;
    tick(); tick();
    chk("rst valid", int'(bus.out_valid), 0);
    chk("rst data",  int'(bus.out_data), 0);
    chk("rst idx",   int'(bus.out_idx), 0);
    chk("rst last",  int'(bus.out_last), 0);
    chk("rst busy",  int'(busy), 0);
    chk("rst ovr",   int'(overrun), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Stall on lane 1 for three cycles.
    bus.out_ready = 1'b1;
    load(1000, 2000, 3000, 4);
    tick();
    cap = 1'b0;
    scramble();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall valid", int'(bus.out_valid), 1);
      chk("stall idx",   int'(bus.out_idx), 1);
      chk("stall data",  int'(bus.out_data), model(2000, 4));
      chk("stall last",  int'(bus.out_last), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("resume idx",  int'(bus.out_idx), 2);
    chk("resume data", int'(bus.out_data), model(3000, 4));
    tick();
    chk("resume end", int'(bus.out_valid), 0);

    // Dropped cap in L1, clear, set-beats-clear, then back-to-back recapture.
    bus.out_ready = 1'b0;
    load(40, 80, 120, 3);
    tick();
    cap = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    load(7, 9, 11, 1);
    tick();
    cap = 1'b0;
    chk("drop ovr",  int'(overrun), 1);
    chk("drop idx",  int'(bus.out_idx), 1);
    chk("drop data", int'(bus.out_data), model(80, 3));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drop L2 data", int'(bus.out_data), model(120, 3));
    chk("drop L2 ovr",  int'(overrun), 1);
    load(1, 1, 1, 0);
    clr_ovr = 1'b1;
    tick();
    cap = 1'b0;
    chk("set wins ovr", int'(overrun), 1);
    chk("set wins idx", int'(bus.out_idx), 2);
    tick();
    clr_ovr = 1'b0;
    chk("clr ovr", int'(overrun), 0);
    bus.out_ready = 1'b1;
    load(7, 9, 11, 1);
    tick();
    cap = 1'b0;
    scramble();
    chk("b2b valid", int'(bus.out_valid), 1);
    chk("b2b idx",   int'(bus.out_idx), 0);
    chk("b2b data",  int'(bus.out_data), model(7, 1));
    chk("b2b ovr",   int'(overrun), 0);
    tick();
    chk("b2b data1", int'(bus.out_data), model(9, 1));
    tick();
    chk("b2b data2", int'(bus.out_data), model(11, 1));
    chk("b2b last",  int'(bus.out_last), 1);
    tick();
    chk("b2b end", int'(bus.out_valid), 0);

    // Reset in the middle of a triplet with overrun set.
    bus.out_ready = 1'b1;
    load(500, 600, 700, 2);
    tick();
    cap = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    cap = 1'b1;
    tick();
    cap = 1'b0;
    chk("pre-rst ovr", int'(overrun), 1);
    rst = 1'b1;
    tick(); tick();
    chk("mid rst valid", int'(bus.out_valid), 0);
    chk("mid rst data",  int'(bus.out_data), 0);
    chk("mid rst idx",   int'(bus.out_idx), 0);
    chk("mid rst last",  int'(bus.out_last), 0);
    chk("mid rst busy",  int'(busy), 0);
    chk("mid rst ovr",   int'(overrun), 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("post rst valid", int'(bus.out_valid), 0);
    tick();
    chk("post rst valid2", int'(bus.out_valid), 0);

    // Randomized triplets with random backpressure.
    for (int n = 0; n < 40; n++) begin
      a = (n % 4 == 0) ? 65535 - int'($urandom_range(0, 300)) : int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      c = int'($urandom_range(0, 1023));
      q = int'($urandom_range(0, 15));
      exp_d[0] = model(a, q);
      exp_d[1] = model(b, q);
      exp_d[2] = model(c, q);
      bus.out_ready = 1'b0;
      load(a, b, c, q);
      tick();
      cap = 1'b0;
      k = 0;
      cyc = 0;
      while (k < 3 && cyc < 60) begin
        scramble();
        chk("rnd valid", int'(bus.out_valid), 1);
        chk("rnd idx",   int'(bus.out_idx), k);
        held = int'(bus.out_data);
        chk("rnd data",  held, exp_d[k]);
        chk("rnd last",  int'(bus.out_last), (k == 2) ? 1 : 0);
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_ready) k++;
        tick();
        cyc++;
      end
      if (k < 3) chk("rnd timeout", k, 3);
      bus.out_ready = 1'b0;
      chk("rnd done", int'(bus.out_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
